// File: rtl/turkey_pkg.sv
// Shared types and constants for the two-beam turkey gate counter.
// The optional debounce filter is enabled with the TURKEY_DEBOUNCE_EN macro.
package turkey_pkg;

  localparam int CNT_W       = 8;
  localparam int CNT_MAX_DEF = 99;

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3,
    WAIT_CLR
  } gate_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Per-beam input conditioning: synchroniser chain, plus a stability filter when
// TURKEY_DEBOUNCE_EN is defined.
module sensor_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beam_i,
  output logic level_o
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1) begin : g_bad_cfg
    $error("sensor_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYC >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], beam_i};
    end
  end

`ifdef TURKEY_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic            raw;
  logic            filt_q;
  logic [DB_W-1:0] db_cnt_q;

  assign raw = sync_q[SYNC_STAGES-1];

  // Filtered level follows the raw level only after it differs for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else if (raw == filt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
      filt_q   <= raw;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign level_o = filt_q;
`else
  assign level_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/turkey_gate_counter.sv
// Direction-decoding gate monitor with saturating head count and peak tracking.
// Optional per-beam debounce filtering is enabled by defining TURKEY_DEBOUNCE_EN.
module turkey_gate_counter
  import turkey_pkg::*;
#(
  parameter int CNT_MAX      = CNT_MAX_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beam_l,
  input  logic             beam_r,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] peak,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             sat_flag
);

  localparam logic [CNT_W-1:0] CntMaxC = CNT_W'(CNT_MAX);

  logic        level_l;
  logic        level_r;
  logic [1:0]  lr;
  gate_state_t state_q;
  logic        commit_in_q;
  logic        commit_out_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  logic             sat_q, sat_d;
  logic             inc_q, dec_q;

  sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_l (
    .clk(clk), .rst_n(rst_n), .beam_i(beam_l), .level_o(level_l)
  );

  sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_r (
    .clk(clk), .rst_n(rst_n), .beam_i(beam_r), .level_o(level_r)
  );

  assign lr = {level_l, level_r};

  // Commit flags are raised on the transition into IDLE and consumed by the count next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      commit_in_q  <= 1'b0;
      commit_out_q <= 1'b0;
    end else begin
      commit_in_q  <= 1'b0;
      commit_out_q <= 1'b0;
      case (state_q)
        IDLE: case (lr)
          2'b10:   state_q <= E1;
          2'b01:   state_q <= X1;
          2'b11:   state_q <= WAIT_CLR;
          default: state_q <= IDLE;
        endcase
        E1: case (lr)
          2'b11:   state_q <= E2;
          2'b00:   state_q <= IDLE;
          2'b01:   state_q <= WAIT_CLR;
          default: state_q <= E1;
        endcase
        E2: case (lr)
          2'b01:   state_q <= E3;
          2'b10:   state_q <= E1;
          2'b00:   state_q <= IDLE;
          default: state_q <= E2;
        endcase
        E3: case (lr)
          2'b00: begin
            state_q     <= IDLE;
            commit_in_q <= 1'b1;
          end
          2'b11:   state_q <= E2;
          2'b10:   state_q <= WAIT_CLR;
          default: state_q <= E3;
        endcase
        X1: case (lr)
          2'b11:   state_q <= X2;
          2'b00:   state_q <= IDLE;
          2'b10:   state_q <= WAIT_CLR;
          default: state_q <= X1;
        endcase
        X2: case (lr)
          2'b10:   state_q <= X3;
          2'b01:   state_q <= X1;
          2'b00:   state_q <= IDLE;
          default: state_q <= X2;
        endcase
        X3: case (lr)
          2'b00: begin
            state_q      <= IDLE;
            commit_out_q <= 1'b1;
          end
          2'b11:   state_q <= X2;
          2'b01:   state_q <= WAIT_CLR;
          default: state_q <= X3;
        endcase
        default: state_q <= (lr == 2'b00) ? IDLE : WAIT_CLR;
      endcase
    end
  end

  // Bounds are checked before the add/sub so the count never wraps; clr wins over a commit.
  always_comb begin
    count_d = count_q;
    peak_d  = peak_q;
    sat_d   = sat_q;
    if (commit_in_q) begin
      if (count_q < CntMaxC) count_d = count_q + 1'b1;
      else                   sat_d   = 1'b1;
    end
    if (commit_out_q) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      else               sat_d   = 1'b1;
    end
    if (count_d > peak_q) peak_d = count_d;
    if (clr) begin
      count_d = '0;
      peak_d  = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      peak_q  <= '0;
      sat_q   <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      sat_q   <= sat_d;
      inc_q   <= commit_in_q;
      dec_q   <= commit_out_q;
    end
  end

  assign count     = count_q;
  assign peak      = peak_q;
  assign sat_flag  = sat_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;

endmodule

// File: tb/tb_turkey_gate_counter.sv
// Directed self-checking bench for turkey_gate_counter (default build, debounce disabled).
module tb_turkey_gate_counter;
  import turkey_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       beam_l;
  logic       beam_r;
  logic       clr;
  logic [7:0] count;
  logic [7:0] peak;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       sat_flag;

  int vectors;
  int miscompares;
  int incSeen;
  int decSeen;
  int incBase;
  int decBase;

  turkey_gate_counter dut (
    .clk(clk), .rst_n(rst_n), .beam_l(beam_l), .beam_r(beam_r), .clr(clr),
    .count(count), .peak(peak), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (inc_pulse === 1'b1) incSeen++;
    if (dec_pulse === 1'b1) decSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] lr, input int cycles);
    {beam_l, beam_r} = lr;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doEntry();
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b01, 10);
    applyStimulus(2'b00, 10);
  endtask

  task automatic doExit();
    applyStimulus(2'b01, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b00, 10);
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic markPulses();
    incBase = incSeen;
    decBase = decSeen;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    incSeen     = 0;
    decSeen     = 0;
    rst_n  = 1'b0;
    beam_l = 1'b0;
    beam_r = 1'b0;
    clr    = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_peak", 32'(peak), 0);
    checkOutput("rst_sat", 32'(sat_flag), 0);
    checkOutput("rst_inc", 32'(inc_pulse), 0);
    checkOutput("rst_dec", 32'(dec_pulse), 0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    markPulses();
    doEntry();
    checkOutput("entry_count", 32'(count), 1);
    checkOutput("entry_inc_pulses", 32'(incSeen - incBase), 1);
    checkOutput("entry_peak", 32'(peak), 1);

    doEntry();
    doEntry();
    checkOutput("preexit_count", 32'(count), 3);
    markPulses();
    doExit();
    checkOutput("exit_count", 32'(count), 2);
    checkOutput("exit_dec_pulses", 32'(decSeen - decBase), 1);
    checkOutput("exit_peak", 32'(peak), 3);

    doEntry();
    doEntry();
    doEntry();
    checkOutput("prebackoff_count", 32'(count), 5);
    markPulses();
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b00, 10);
    checkOutput("backoff_count", 32'(count), 5);
    checkOutput("backoff_pulses", 32'((incSeen - incBase) + (decSeen - decBase)), 0);

    markPulses();
    applyStimulus(2'b10, 10);
    applyStimulus(2'b01, 10);
    checkOutput("illegal_state", 32'(dut.state_q), 32'(WAIT_CLR));
    applyStimulus(2'b11, 10);
    checkOutput("waitclr_hold", 32'(dut.state_q), 32'(WAIT_CLR));
    checkOutput("waitclr_count", 32'(count), 5);
    applyStimulus(2'b00, 10);
    checkOutput("waitclr_exit", 32'(dut.state_q), 32'(IDLE));
    checkOutput("illegal_pulses", 32'((incSeen - incBase) + (decSeen - decBase)), 0);

    for (int i = 0; i < 94; i++) doEntry();
    checkOutput("preload_count", 32'(count), 99);
    checkOutput("preload_peak", 32'(peak), 99);
    checkOutput("preload_sat", 32'(sat_flag), 0);
    markPulses();
    doEntry();
    checkOutput("sat_hi_count", 32'(count), 99);
    checkOutput("sat_hi_flag", 32'(sat_flag), 1);
    checkOutput("sat_hi_inc", 32'(incSeen - incBase), 1);

    pulseClr();
    checkOutput("clr_count", 32'(count), 0);
    checkOutput("clr_peak", 32'(peak), 0);
    checkOutput("clr_sat", 32'(sat_flag), 0);

    markPulses();
    doExit();
    checkOutput("sat_lo_count", 32'(count), 0);
    checkOutput("sat_lo_flag", 32'(sat_flag), 1);
    checkOutput("sat_lo_dec", 32'(decSeen - decBase), 1);

    pulseClr();
    for (int i = 0; i < 7; i++) doEntry();
    checkOutput("pre_clrcommit_count", 32'(count), 7);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b01, 10);
    // Release: two sync edges, FSM commit edge, then the count-update edge meets clr.
    applyStimulus(2'b00, 3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clrcommit_inc", 32'(inc_pulse), 1);
    checkOutput("clrcommit_count", 32'(count), 0);
    checkOutput("clrcommit_peak", 32'(peak), 0);
    repeat (5) @(negedge clk);
    checkOutput("clrcommit_later", 32'(count), 0);

    for (int i = 0; i < 4; i++) doEntry();
    checkOutput("pre_rst_count", 32'(count), 4);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    checkOutput("pre_rst_state", 32'(dut.state_q), 32'(E2));
    rst_n  = 1'b0;
    beam_l = 1'b0;
    beam_r = 1'b0;
    @(negedge clk);
    checkOutput("midrst_count", 32'(count), 0);
    checkOutput("midrst_peak", 32'(peak), 0);
    checkOutput("midrst_sat", 32'(sat_flag), 0);
    checkOutput("midrst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    applyStimulus(2'b00, 10);
    doEntry();
    checkOutput("postrst_count", 32'(count), 1);
    checkOutput("postrst_peak", 32'(peak), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/turkey_gate_counter.md
Name: turkey_gate_counter

Overview:
- Two-beam gate monitor that decodes turkey passage direction from left/right break-beam sensors and keeps a saturating head count.
- Sits directly upstream of the 8-bit 2:1 display-select mux.
- Its two 8-bit outputs are the mux's in0 (live count) and in1 (peak count); the display stage drives the mux select.

Parameters:
- CNT_MAX, 99, upper saturation bound for count (≤255).
- SYNC_STAGES, 2, synchroniser flops per sensor input (≥2).
- DEBOUNCE_CYC, 1000, stable cycles required per sensor level (only when TURKEY_DEBOUNCE_EN is defined).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- beam_l  input  1  left (outside) beam blocked, async, active-high.
- beam_r  input  1  right (inside) beam blocked, async, active-high.
- clr  input  1  synchronous clear of count and peak.
- count  output  8  current head count, to mux in0.
- peak  output  8  highest count since reset/clr, to mux in1.
- inc_pulse  output  1  one-cycle pulse on committed entry.
- dec_pulse  output  1  one-cycle pulse on committed exit.
- sat_flag  output  1  sticky; set on any saturated inc/dec, cleared by clr.

Behaviour:
- Reset (async assert, sync-free deassert): count=0, peak=0, inc_pulse=0, dec_pulse=0, sat_flag=0, FSM=IDLE, synchronisers=0.
- Inputs pass SYNC_STAGES flops. The synchronised pair {L,R} drives the FSM.
- FSM states and transitions:
  - IDLE: 10→E1; 01→X1; 11→WAIT_CLR; 00 stay.
  - E1: 11→E2; 00→IDLE (abort); 01→WAIT_CLR.
  - E2: 01→E3; 10→E1 (back-off); 00→IDLE; 11 stay.
  - E3: 00→IDLE with entry commit; 11→E2; 10→WAIT_CLR.
  - X1/X2/X3: mirror of E1/E2/E3 with L and R swapped. X3 on 00 → IDLE with exit commit.
  - WAIT_CLR: 00→IDLE, no commit; else stay.
- Entry commit: the cycle after the FSM samples 00 in E3:
  - count<CNT_MAX → count+1 and inc_pulse=1.
  - count==CNT_MAX → count holds, sat_flag=1, inc_pulse=1.
- Exit commit: same, mirrored:
  - count>0 → count−1 and dec_pulse=1.
  - count==0 → count holds, sat_flag=1, dec_pulse=1.
- Latency: beam edge to FSM state change is SYNC_STAGES+1 cycles. Final-beam release to count update is SYNC_STAGES+2 cycles.
- peak: updated the same cycle as count whenever the new count > peak. peak never decreases except on clr.
- clr: next cycle count=0, peak=0, sat_flag=0. clr has priority over a same-cycle commit (the commit is dropped; its pulse still fires). The FSM is unaffected by clr.
- Arithmetic: unsigned 8-bit. The compare is done before add/sub, so there is no wrap-around.
- A reset asserted mid-traversal discards the partial sequence.

Optional Feature:
- Macro TURKEY_DEBOUNCE_EN.
- Defined: each synchronised sensor passes a debounce filter. The filtered level changes only after the raw level has been stable DEBOUNCE_CYC consecutive cycles. Its counter is clog2(DEBOUNCE_CYC+1) bits and resets to 0. This adds DEBOUNCE_CYC cycles of latency.
- Undefined: synchroniser output feeds the FSM directly; DEBOUNCE_CYC is ignored.

Decomposition:
- Package turkey_pkg:
  - gate_state_t enum (IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLR).
  - CNT_W=8.
  - Default CNT_MAX constant.
- Sub-module sensor_debounce: one instance per beam. It contains the synchroniser and, under TURKEY_DEBOUNCE_EN, the stability counter.

Test Plan:
- Entry sequence L=1/R=0, 1/1, 0/1, 0/0, each held 10 cycles → count 0→1, single inc_pulse, peak=1.
- Exit sequence 01,11,10,00 from count=3 → count=2, single dec_pulse, peak stays 3.
- Back-off 10,11,10,00 from count=5 → count stays 5, no pulses. Illegal jump 10→01 → WAIT_CLR, no count change until 00.
- Saturation at both bounds:
  - Preload to 99 (99 entries), one more entry → count=99, sat_flag=1, inc_pulse seen.
  - clr → count=0, peak=0, sat_flag=0.
  - One exit → count stays 0, sat_flag=1.
- clr asserted in the commit cycle of an entry at count=7 → count=0, peak=0, inc_pulse=1.
- rst_n low for 1 cycle while in E2 at count=4 → all outputs 0, FSM IDLE. A subsequent full entry gives count=1.
